// File: rtl/imem_arb_pkg.sv
// imem_arb_pkg: shared owner encoding, default parameters and counter sizing for imem_arbiter.
package imem_arb_pkg;
  typedef enum logic [1:0] {OWN_NONE, OWN_F, OWN_L_RD} owner_t;
  localparam int DEF_ADDR_W = 62;
  localparam int DEF_DATA_W = 32;
  localparam int DEF_MAX_WAIT = 8;
  function automatic int cnt_w(input int max_wait);
    return $clog2(max_wait + 1);
  endfunction
endpackage

// File: rtl/imem_arb_starve_ctr.sv
// imem_arb_starve_ctr: saturating loader wait counter; force_l grants the loader once it has waited MAX_WAIT cycles.
module imem_arb_starve_ctr
  import imem_arb_pkg::*;
#(
  parameter int MAX_WAIT = DEF_MAX_WAIT
) (
  input  logic clk,
  input  logic rst,
  input  logic l_req,
  input  logic l_ready,
  output logic force_l
);
  localparam int CW = cnt_w(MAX_WAIT);
  logic [CW-1:0] cnt;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) cnt <= '0;
    else if (!l_req || l_ready) cnt <= '0;
    else if (cnt != CW'(MAX_WAIT)) cnt <= cnt + 1'b1;
  end
  assign force_l = l_req && (cnt == CW'(MAX_WAIT));
endmodule

// File: rtl/imem_arbiter.sv
// imem_arbiter: fetch-priority arbiter for the instruction memory with one-cycle response routing.
// Define IMEM_ARB_FAIRNESS_EN to add the loader starvation guard.
module imem_arbiter
  import imem_arb_pkg::*;
#(
  parameter int ADDR_W   = DEF_ADDR_W,
  parameter int DATA_W   = DEF_DATA_W,
  parameter int MAX_WAIT = DEF_MAX_WAIT
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              f_req,
  input  logic [ADDR_W-1:0] f_addr,
  output logic              f_ready,
  input  logic              f_flush,
  output logic              f_rvalid,
  output logic [DATA_W-1:0] f_rdata,
  input  logic              l_req,
  input  logic              l_we,
  input  logic [ADDR_W-1:0] l_addr,
  input  logic [DATA_W-1:0] l_wdata,
  output logic              l_ready,
  output logic              l_rvalid,
  output logic [DATA_W-1:0] l_rdata,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_we,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_q
);
  owner_t owner;
  logic   force_l;
  if (MAX_WAIT < 1 || MAX_WAIT > 255) begin : g_bad_max_wait
    $error("imem_arbiter: MAX_WAIT must be in 1..255");
  end
`ifdef IMEM_ARB_FAIRNESS_EN
  imem_arb_starve_ctr #(.MAX_WAIT(MAX_WAIT)) u_starve (
    .clk(clk),
    .rst(rst),
    .l_req(l_req),
    .l_ready(l_ready),
    .force_l(force_l)
  );
`else
  assign force_l = 1'b0;
`endif
  always_comb begin
    f_ready   = !rst && f_req && !force_l;
    l_ready   = !rst && l_req && (force_l || !f_req);
    mem_addr  = l_ready ? l_addr : f_addr;
    mem_we    = l_ready && l_we;
    mem_wdata = l_wdata;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) owner <= OWN_NONE;
    else owner <= f_ready ? OWN_F : (l_ready && !l_we) ? OWN_L_RD : OWN_NONE;
  end
  // flush only masks the response; the owner still advances with this cycle's grant
  assign f_rvalid = (owner == OWN_F) && !f_flush;
  assign l_rvalid = (owner == OWN_L_RD);
  assign f_rdata  = mem_q;
  assign l_rdata  = mem_q;
endmodule
